pc_gen_unit: RTL and testbench

- Parametrised successor to the IF-stage program counter register.
- Generates the fetch PC and the fetch-enable strobe (ce_o).
- Redirects come from branch/jump resolution and from the interrupt/exception controller; interrupt redirects take priority over jumps.
- A redirect that arrives while IF is stalled is held in a pending buffer and applied when the stall releases, so it is never lost.

---
 rtl/pc_gen_unit.sv | 143 ++++++++++++++
 tb/tb_pc_gen_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// IF-stage fetch PC generator with redirect priority and a stall-safe pending redirect buffer.
// Optional misaligned-target reporting is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen_unit #(
    parameter int unsigned                  ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC    = '0,
    parameter int unsigned                  INST_BYTES  = 4,
    parameter int unsigned                  STALL_WIDTH = 6,
    parameter int unsigned                  STALL_BIT   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   flush_jump_i,
    input  logic [ADDR_WIDTH-1:0]  jump_pc_i,
    input  logic                   flush_int_i,
    input  logic [ADDR_WIDTH-1:0]  int_pc_i,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic                   ce_o,
    output logic                   redir_pend_o,
    output logic                   misalign_o,
    output logic [ADDR_WIDTH-1:0]  misalign_addr_o
);

    localparam logic                  STOP     = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(INST_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] INC      = ADDR_WIDTH'(INST_BYTES);

    if (INST_BYTES < 1 || INST_BYTES > 8 ||
        (INST_BYTES & (INST_BYTES - 1)) != 0) begin : g_bad_inst_bytes
        $error("INST_BYTES must be a power of two in 1..8");
    end

    logic                  ce_q;
    logic [ADDR_WIDTH-1:0] pc_q,      pc_d;
    logic                  pend_v_q,  pend_v_d;
    logic                  pend_int_q, pend_int_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic                  frozen;
    logic                  redir_v;
    logic [ADDR_WIDTH-1:0] redir_pc;
    logic                  apply;
    logic                  unused_stall;

    assign frozen       = (stall_i[STALL_BIT] == STOP);
    assign unused_stall = ^stall_i;

    always_comb begin
        redir_v  = 1'b0;
        redir_pc = pend_pc_q;
        if (flush_int_i) begin
            redir_v  = 1'b1;
            redir_pc = int_pc_i;
        end else if (pend_v_q) begin
            redir_v  = 1'b1;
            redir_pc = pend_pc_q;
        end else if (flush_jump_i) begin
            redir_v  = 1'b1;
            redir_pc = jump_pc_i;
        end
    end

    assign apply = ce_q && !frozen && redir_v;

    always_comb begin
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_int_d = pend_int_q;
        pend_pc_d  = pend_pc_q;
        if (ce_q) begin
            if (frozen) begin
                // A jump may replace an older jump but never a pending trap.
                if (flush_int_i) begin
                    pend_v_d   = 1'b1;
                    pend_int_d = 1'b1;
                    pend_pc_d  = int_pc_i;
                end else if (flush_jump_i && !(pend_v_q && pend_int_q)) begin
                    pend_v_d   = 1'b1;
                    pend_int_d = 1'b0;
                    pend_pc_d  = jump_pc_i;
                end
            end else begin
                pend_v_d   = 1'b0;
                pend_int_d = 1'b0;
                if (redir_v) begin
                    pc_d = redir_pc & ~OFF_MASK;
                end else begin
                    pc_d = pc_q + INC;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_int_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            ce_q       <= 1'b1;
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_int_q <= pend_int_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign pc_o         = pc_q;
    assign ce_o         = ce_q;
    assign redir_pend_o = pend_v_q;

`ifdef PC_MISALIGN_TRAP_EN
    logic                  mis_q;
    logic [ADDR_WIDTH-1:0] mis_addr_q;
    logic                  mis_hit;

    assign mis_hit = apply && ((redir_pc & OFF_MASK) != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            mis_q <= mis_hit;
            if (mis_hit) begin
                mis_addr_q <= redir_pc;
            end
        end
    end

    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
`else
    logic unused_apply;

    assign unused_apply    = apply;
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: stimulus pushes expected post-edge state,
// a monitor pops and compares one entry after each rising edge.
module tb_pc_gen_unit;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        fj;
    logic [31:0] jpc;
    logic        fi;
    logic [31:0] ipc;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
    logic [31:0] maddr;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pc_gen_unit dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_i         (stall),
        .flush_jump_i    (fj),
        .jump_pc_i       (jpc),
        .flush_int_i     (fi),
        .int_pc_i        (ipc),
        .pc_o            (pc),
        .ce_o            (ce),
        .redir_pend_o    (pend),
        .misalign_o      (mis),
        .misalign_addr_o (maddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: one expected entry per rising edge while stimulus runs.
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("step%0d pc", e.id), pc, e.pc);
            chk($sformatf("step%0d ce", e.id), 32'(ce), 32'(e.ce));
            chk($sformatf("step%0d pend", e.id), 32'(pend), 32'(e.pend));
            chk($sformatf("step%0d mis", e.id), 32'(mis), 32'(e.mis));
            chk($sformatf("step%0d maddr", e.id), maddr, e.maddr);
        end
    end

    task automatic step(input int id, input logic s, input logic j,
                        input logic [31:0] jp, input logic i,
                        input logic [31:0] ip, input logic [31:0] epc,
                        input logic ep, input logic em,
                        input logic [31:0] ema, input logic [5:0] sv = 6'd0);
        exp_t e;
        @(negedge clk);
        stall = s ? 6'b000001 : sv;
        fj    = j;
        jpc   = jp;
        fi    = i;
        ipc   = ip;
        e.id    = id;
        e.pc    = epc;
        e.ce    = 1'b1;
        e.pend  = ep;
        e.mis   = FEAT ? em : 1'b0;
        e.maddr = FEAT ? ema : 32'h0;
        q.push_back(e);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " ce"}, 32'(ce), 32'h0);
        chk({tag, " pc"}, pc, 32'h0);
        chk({tag, " pend"}, 32'(pend), 32'h0);
        chk({tag, " mis"}, 32'(mis), 32'h0);
        chk({tag, " maddr"}, maddr, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = '0;
        fj    = 1'b0;
        jpc   = '0;
        fi    = 1'b0;
        ipc   = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_checks("reset");
        rst_n = 1'b1;

        // Enable edge ignores redirects, then sequential fetch.
        step(1,  0, 1, 32'h500, 0, 0, 32'h0,   0, 0, 0);
        step(2,  0, 0, 0, 0, 0, 32'h4,   0, 0, 0);
        step(3,  0, 0, 0, 0, 0, 32'h8,   0, 0, 0);
        step(4,  0, 0, 0, 0, 0, 32'hC,   0, 0, 0);
        step(5,  0, 0, 0, 0, 0, 32'h10,  0, 0, 0);
        step(6,  0, 1, 32'h200, 0, 0, 32'h200, 0, 0, 0);
        step(7,  0, 0, 0, 0, 0, 32'h204, 0, 0, 0);
        step(8,  0, 1, 32'h3C, 0, 0, 32'h3C, 0, 0, 0);
        step(9,  0, 0, 0, 0, 0, 32'h40,  0, 0, 0);
        // Stall, jump buffered, int overrides it, applied on release.
        step(10, 1, 0, 0, 0, 0, 32'h40,  0, 0, 0);
        step(11, 1, 1, 32'h300, 0, 0, 32'h40, 1, 0, 0);
        step(12, 1, 0, 0, 0, 0, 32'h40,  1, 0, 0);
        step(13, 1, 0, 0, 1, 32'h80, 32'h40, 1, 0, 0);
        step(14, 0, 0, 0, 0, 0, 32'h80,  0, 0, 0);
        step(15, 0, 0, 0, 0, 0, 32'h84,  0, 0, 0);
        step(16, 0, 1, 32'h500, 1, 32'h1000, 32'h1000, 0, 0, 0);
        step(17, 0, 0, 0, 0, 0, 32'h1004, 0, 0, 0);
        // Newer jump replaces older jump.
        step(18, 1, 1, 32'h600, 0, 0, 32'h1004, 1, 0, 0);
        step(19, 1, 1, 32'h700, 0, 0, 32'h1004, 1, 0, 0);
        step(20, 0, 0, 0, 0, 0, 32'h700, 0, 0, 0);
        // Jump never replaces a pending int.
        step(21, 1, 0, 0, 1, 32'h900, 32'h700, 1, 0, 0);
        step(22, 1, 1, 32'h800, 0, 0, 32'h700, 1, 0, 0);
        step(23, 0, 0, 0, 0, 0, 32'h900, 0, 0, 0);
        // Both while frozen stores int; a fresh int beats pending on release.
        step(24, 1, 1, 32'hB00, 1, 32'hA00, 32'h900, 1, 0, 0);
        step(25, 0, 0, 0, 1, 32'hC00, 32'hC00, 0, 0, 0);
        step(26, 0, 0, 0, 0, 0, 32'hC04, 0, 0, 0);
        // Pending jump beats a new jump on release.
        step(27, 1, 1, 32'hD00, 0, 0, 32'hC04, 1, 0, 0);
        step(28, 0, 1, 32'hE00, 0, 0, 32'hD00, 0, 0, 0);
        step(29, 0, 0, 0, 0, 0, 32'hD04, 0, 0, 0);
        // Misaligned target is masked.
        step(30, 0, 1, 32'h206, 0, 0, 32'h204, 0, 1, 32'h206);
        step(31, 0, 0, 0, 0, 0, 32'h208, 0, 0, 32'h206);
        // Wrap-around.
        step(32, 0, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 0, 0, 32'h206);
        step(33, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'h206);
        step(34, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h206);
        // Stall bits other than the IF bit do not freeze.
        step(35, 0, 0, 0, 0, 0, 32'h4, 0, 0, 32'h206, 6'b111110);
        step(36, 1, 1, 32'h40, 0, 0, 32'h4, 1, 0, 32'h206);

        // Asynchronous reset mid-stall with a pending redirect.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks("async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(37, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        step(38, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0);
        step(39, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
